// File: rtl/serv_wb_mem_responder.sv
// Single-ported word memory answering SERV's ibus and dbus Wishbone requests,
// with fixed dbus priority, programmable wait states and a backdoor loader.
module serv_wb_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    input  logic        i_ld_en,
    input  logic [31:0] i_ld_adr,
    input  logic [31:0] i_ld_dat,
    output logic        o_busy
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [31:0] r_mem [DEPTH_WORDS];

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_owner;
    logic [31:0] r_ibus_rdt;
    logic [31:0] r_dbus_rdt;

    logic [AW-1:0] w_iidx;
    logic [AW-1:0] w_didx;
    logic [AW-1:0] w_lidx;
    logic          w_start;
    logic          w_owner_nxt;
    logic          w_owner_cyc;
    logic          w_capture;
    logic          w_cap_owner;
    logic          w_wr_commit;
    logic          w_unused;

    // Upper address bits wrap modulo the memory size; byte offset is ignored.
    assign w_iidx = i_ibus_adr[AW+1:2];
    assign w_didx = i_dbus_adr[AW+1:2];
    assign w_lidx = i_ld_adr[AW+1:2];
    assign w_unused = ^{i_ibus_adr[31:AW+2], i_ibus_adr[1:0],
                        i_dbus_adr[31:AW+2], i_dbus_adr[1:0],
                        i_ld_adr[31:AW+2],   i_ld_adr[1:0]};

    assign w_start     = (r_state == S_IDLE) && !i_ld_en && (i_ibus_cyc || i_dbus_cyc);
    assign w_owner_nxt = i_dbus_cyc;
    assign w_owner_cyc = r_owner ? i_dbus_cyc : i_ibus_cyc;

    // Read data is latched on the edge that enters ACK, from IDLE or WAIT.
    assign w_capture   = (w_start && (WAIT_INIT == 4'd0)) ||
                         ((r_state == S_WAIT) && w_owner_cyc && (r_cnt == 4'd1));
    assign w_cap_owner = (r_state == S_IDLE) ? w_owner_nxt : r_owner;

    assign w_wr_commit = (r_state == S_ACK) && r_owner && i_dbus_we && i_dbus_cyc;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_owner    <= 1'b0;
            r_ibus_rdt <= 32'd0;
            r_dbus_rdt <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_owner <= w_owner_nxt;
                        r_cnt   <= WAIT_INIT;
                        r_state <= (WAIT_INIT == 4'd0) ? S_ACK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (!w_owner_cyc) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == 4'd1) begin
                        r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_capture) begin
                if (w_cap_owner) begin
                    r_dbus_rdt <= r_mem[w_didx];
                end else begin
                    r_ibus_rdt <= r_mem[w_iidx];
                end
            end
        end
    end

    // Memory is never reset; the backdoor only writes while IDLE.
    always_ff @(posedge clk) begin
        if ((r_state == S_IDLE) && i_ld_en) begin
            r_mem[w_lidx] <= i_ld_dat;
        end else if (w_wr_commit) begin
            for (int k = 0; k < 4; k++) begin
                if (i_dbus_sel[k]) begin
                    r_mem[w_didx][8*k +: 8] <= i_dbus_dat[8*k +: 8];
                end
            end
        end
    end

    assign o_ibus_ack = (r_state == S_ACK) && !r_owner && i_ibus_cyc;
    assign o_dbus_ack = (r_state == S_ACK) &&  r_owner && i_dbus_cyc;
    assign o_ibus_rdt = r_ibus_rdt;
    assign o_dbus_rdt = r_dbus_rdt;
    assign o_busy     = (r_state != S_IDLE);

endmodule
